// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle expiry tick and a
// sticky done flag. With auto_reload set it reloads on expiry and keeps
// running, which makes it a periodic tick generator.
//
// The count only decrements while in RUN, and RUN is only entered with a
// non-zero count, so the count can never wrap below zero.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,       // active-high synchronous reset
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             tick
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  // Timer FSM: reset, then load, then per-state counting; outputs registered.
  // running is updated together with state so it always equals (state == RUN).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      running    <= 1'b0;
      done       <= 1'b0;
      tick       <= 1'b0;
    end else begin
      // tick is a single-cycle pulse unless re-asserted below
      tick <= 1'b0;
      if (load) begin
        // load beats any terminal decrement in the same cycle
        count      <= load_value;
        reload_reg <= load_value;
        done       <= 1'b0;
        if (load_value != ZERO) begin
          state   <= RUN;
          running <= 1'b1;
        end else begin
          state   <= IDLE;
          running <= 1'b0;
        end
      end else begin
        case (state)
          RUN: begin
            if (enable) begin
              if (count == ONE) begin
                tick <= 1'b1;
                done <= 1'b1;
                if (auto_reload) begin
                  count <= reload_reg;
                end else begin
                  count   <= ZERO;
                  state   <= EXPIRED;
                  running <= 1'b0;
                end
              end else begin
                count <= count - ONE;
              end
            end
          end
          // IDLE and EXPIRED hold everything until load or reset
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer. Inputs change 1 time unit after each
// rising edge; outputs are checked at the same point, after the edge settles.
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             done;
  logic             tick;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .load        (load),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .count       (count),
    .running     (running),
    .done        (done),
    .tick        (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one compare point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // compare all four outputs
  task automatic chk_all(input string tag, input int c, input int r, input int d, input int t);
    chk({tag, ".count"},   32'(count),   c);
    chk({tag, ".running"}, 32'(running), r);
    chk({tag, ".done"},    32'(done),    d);
    chk({tag, ".tick"},    32'(tick),    t);
  endtask

  // apply inputs, take one rising edge, settle past it
  task automatic cyc(input logic en, input logic ld, input logic [WIDTH-1:0] lv);
    enable     = en;
    load       = ld;
    load_value = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; load = 1'b0; load_value = '0; auto_reload = 1'b0;

    // ---- reset then idle
    cyc(1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 4'd0);
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(i[0], 1'b0, 4'd0);
      chk_all($sformatf("idle%0d", i), 0, 0, 0, 0);
    end

    // ---- one-shot 5 (enable high in load cycle is ignored)
    cyc(1'b1, 1'b1, 4'd5);
    chk_all("os_load", 5, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      chk_all($sformatf("os%0d", i), 5 - i, (i < 5) ? 1 : 0, (i == 5) ? 1 : 0, (i == 5) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      chk_all($sformatf("os_exp%0d", i), 0, 0, 1, 0);
    end

    // ---- gapped enable, load 3, pattern 1,0,0,1,0,1
    cyc(1'b0, 1'b1, 4'd3);
    chk_all("gap_load", 3, 1, 0, 0);
    begin
      logic [5:0] pat;
      int         expc [6];
      pat  = 6'b101001;  // bit i = enable at step i
      expc = '{2, 2, 2, 1, 1, 0};
      for (int i = 0; i < 6; i++) begin
        cyc(pat[i], 1'b0, 4'd0);
        chk_all($sformatf("gap%0d", i), expc[i], (i < 5) ? 1 : 0, (i == 5) ? 1 : 0, (i == 5) ? 1 : 0);
      end
    end

    // ---- auto-reload period 4, ticks on enabled cycles 4, 8, 12
    auto_reload = 1'b1;
    cyc(1'b1, 1'b1, 4'd4);
    chk_all("ar_load", 4, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      chk_all($sformatf("ar%0d", i), ((i % 4) == 0) ? 4 : 4 - (i % 4), 1,
              (i >= 4) ? 1 : 0, ((i % 4) == 0) ? 1 : 0);
    end

    // ---- load 15 coincident with terminal decrement: load wins
    auto_reload = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      chk_all($sformatf("pre_term%0d", i), 4 - i, 1, 1, 0);
    end
    cyc(1'b1, 1'b1, 4'd15);
    chk_all("load_wins", 15, 1, 0, 0);

    // ---- maximum value: 15 enabled cycles to the tick
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      chk_all($sformatf("max%0d", i), 15 - i, (i < 15) ? 1 : 0, (i == 15) ? 1 : 0, (i == 15) ? 1 : 0);
    end

    // ---- load 0 goes to IDLE and stays there
    cyc(1'b1, 1'b1, 4'd0);
    chk_all("load0", 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      chk_all($sformatf("load0_idle%0d", i), 0, 0, 0, 0);
    end

    // ---- load 1 with auto-reload: tick every enabled cycle
    auto_reload = 1'b1;
    cyc(1'b1, 1'b1, 4'd1);
    chk_all("one_load", 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      chk_all($sformatf("one%0d", i), 1, 1, 1, 1);
    end

    // ---- reset mid-run beats load and enable
    auto_reload = 1'b0;
    cyc(1'b0, 1'b1, 4'd9);
    chk_all("rst_load", 9, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      chk_all($sformatf("rst_pre%0d", i), 9 - i, 1, 0, 0);
    end
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 4'd7);
    chk_all("rst_mid", 0, 0, 0, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      chk_all($sformatf("rst_post%0d", i), 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter/timer; the count-down counterpart of the team's enable-gated 4-bit up counter.
- Loads a start value, decrements once per enabled cycle, and signals expiry with a one-cycle tick and a sticky done flag.
- Optional auto-reload turns it into a periodic tick generator.
- Sits behind the tile's dedicated inputs and drives count/status onto dedicated outputs.

Parameters:
- WIDTH, 4, width of count, load_value and the internal reload register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-high reset (1 = reset), sampled on the rising edge of clk.
- enable  input  1  count enable; one decrement per clk edge while high in RUN.
- load  input  1  load strobe; captures load_value.
- load_value  input  WIDTH  start/reload value.
- auto_reload  input  1  1 = reload on expiry and keep running; 0 = stop at zero.
- count  output  WIDTH  current count (registered).
- running  output  1  high while the FSM is in RUN.
- done  output  1  sticky expiry flag.
- tick  output  1  one-cycle expiry pulse (registered).

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - count=0, reload_reg=0, state=IDLE, running=0, done=0, tick=0.
  - Reset overrides load, enable and any in-progress count, including mid-RUN.
- FSM states are IDLE, RUN and EXPIRED; running = (state==RUN), registered/decoded from state only.
- load=1, any state (highest priority after reset):
  - count<=load_value, reload_reg<=load_value, done<=0, tick<=0.
  - If load_value!=0: next state RUN. If load_value==0: next state IDLE.
  - enable is ignored in the load cycle.
- RUN, load=0, enable=0: count holds; tick<=0.
- RUN, load=0, enable=1, count>1: count<=count-1; tick<=0.
- RUN, load=0, enable=1, count==1 (terminal):
  - tick<=1 and done<=1 on this edge.
  - If auto_reload=1: count<=reload_reg, stay in RUN.
  - If auto_reload=0: count<=0, go to EXPIRED.
- auto_reload is sampled only at the terminal edge; changing it mid-count is legal.
- EXPIRED: count holds 0, done=1, enable ignored, tick<=0; leaves only on load or reset.
- IDLE: count holds, enable ignored, tick=0.
- Timing:
  - Latency from the load edge to the first tick = N enabled cycles for load_value=N; tick rises on the Nth enabled edge.
  - Auto-reload period = reload_reg enabled cycles between ticks.
- tick is never high for two consecutive cycles unless reload_reg==1 with enable continuously high, in which case tick stays high every cycle.
- Arithmetic is unsigned, modulo 2^WIDTH. The count never underflows: 0 is never decremented, since RUN always holds count>=1.
- load coincident with a terminal decrement: load wins; no tick, done cleared.
- Maximum value: load_value=2^WIDTH-1 gives 15 enabled cycles to the tick at WIDTH=4.

Test Plan:
- Reset then idle: assert rst_n=1 for 2 cycles, release, toggle enable for 5 cycles -> count=0, running=0, done=0, tick=0 throughout.
- One-shot: load 5, enable continuously -> count 5,4,3,2,1,0 on successive edges; tick=1 for exactly the edge where count goes to 0; done=1 and stays; state EXPIRED; further enable leaves count=0.
- Gapped enable: load 3, enable pattern 1,0,0,1,0,1 -> count 3,2,2,2,1,1,0; tick only on the final edge.
- Auto-reload: auto_reload=1, load 4, enable high 12 cycles -> tick pulses on cycles 4, 8 and 12 after the load; count sequence 3,2,1,4,3,2,1,4...; running stays 1; done=1 after the first tick.
- Priority and corners:
  - load 15 at count==1 with enable=1 -> count=15, no tick, done=0.
  - load 0 -> count=0, IDLE, running=0.
  - load 1 with auto_reload=1 and enable high -> tick high every cycle.
- Reset mid-operation: load 9, enable 4 cycles (count=5), assert rst_n=1 with enable and load high -> next edge count=0, running=0, done=0, tick=0.
